systolic_seq_ctrl: RTL

- Sequencer for the N x N systolic MAC array.
- Accepts one start command and runs one matrix-tile pass: accumulator clear, skewed operand feed, pipeline flush, then row-by-row result drain under a ready/valid handshake.
- Generates per-lane feed enables for row (activation) and column (weight) edge buffers; signals completion with a one-cycle done pulse.
- Sits between the host command interface and the array / edge buffers / result collector.

---
 rtl/systolic_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// Pass sequencer for an N x N systolic MAC array: clear, skewed feed, flush,
// then a row-by-row result drain under valid/ready, ending in a done pulse.
module systolic_seq_ctrl #(
   parameter int N       = 4,
   parameter int K       = 4,
   parameter int MAC_LAT = 1,
   parameter int CW      = $clog2(K + 2*N + MAC_LAT) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  acc_clr,
   output logic                  feed_en,
   output logic [CW-1:0]         feed_t,
   output logic [N-1:0]          row_lane_en,
   output logic [N-1:0]          col_lane_en,
   output logic                  drain_valid,
   output logic [$clog2(N)-1:0]  drain_row,
   input  logic                  out_ready,
   output logic                  done
);

   localparam int RW = $clog2(N);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FEED  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Terminal values of the phase counter and the drain row counter.
   localparam logic [CW-1:0] FEED_LAST  = CW'(K + N - 2);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(N - 2 + MAC_LAT);
   localparam logic [RW-1:0] LAST_ROW   = RW'(N - 1);

   // Handshake: a result row transfers on any cycle where drain_valid and
   // out_ready are both high; drain_valid and drain_row hold while stalled.

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   logic [N-1:0]  lane_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d = S_CLEAR;
                  cnt_d   = '0;
                  row_d   = '0;
               end
            end
            S_CLEAR: begin
               state_d = S_FEED;
               cnt_d   = '0;
            end
            S_FEED: begin
               if (cnt_q == FEED_LAST) begin
                  state_d = S_FLUSH;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_FLUSH: begin
               if (cnt_q == FLUSH_LAST) begin
                  state_d = S_DRAIN;
                  cnt_d   = '0;
                  row_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (row_q == LAST_ROW) begin
                     state_d = S_DONE;
                     row_d   = '0;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               row_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
      end
   end

   // Lane i is live for K cycles starting at t = i, giving the diagonal skew.
   always_comb begin
      int t;
      lane_en = '0;
      t = int'(cnt_q);
      if (state_q == S_FEED) begin
         for (int i = 0; i < N; i++) begin
            if ((t >= i) && (t < i + K)) lane_en[i] = 1'b1;
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign acc_clr     = (state_q == S_CLEAR);
   assign feed_en     = (state_q == S_FEED);
   assign feed_t      = (state_q == S_FEED) ? cnt_q : '0;
   assign row_lane_en = lane_en;
   assign col_lane_en = lane_en;
   assign drain_valid = (state_q == S_DRAIN);
   assign drain_row   = (state_q == S_DRAIN) ? row_q : '0;
   assign done        = (state_q == S_DONE);

endmodule
